// File: rtl/lookup_if.sv
// Host/memory-side signal bundle of the BCP lookup core: clause loading,
// unit-literal streaming and assignment-stack readout.
interface lookup_if #(
    parameter int LIT_W      = 8,
    parameter int NODE_DEPTH = 16
);
    localparam int PTR_W = $clog2(NODE_DEPTH) + 1;

    logic                 halt;
    logic [3*LIT_W-1:0]   node_in;
    logic                 node_in_valid;
    logic                 change_eng;
    logic [PTR_W-1:0]     dummy_ptr;
    logic                 dummy_ptr_valid;
    logic [LIT_W-1:0]     mem2uca;
    logic                 mem2uca_valid;
    logic                 mem2uca_done;
    logic                 conflict;
    logic                 mstack_pop;
    logic                 mstack_empty;
    logic [LIT_W-1:0]     mstack_lit;

    modport master (
        output halt, node_in, node_in_valid, change_eng, dummy_ptr, dummy_ptr_valid,
               mem2uca, mem2uca_valid, mem2uca_done, mstack_pop,
        input  conflict, mstack_empty, mstack_lit
    );

    modport slave (
        input  halt, node_in, node_in_valid, change_eng, dummy_ptr, dummy_ptr_valid,
               mem2uca, mem2uca_valid, mem2uca_done, mstack_pop,
        output conflict, mstack_empty, mstack_lit
    );
endinterface

// File: rtl/lookup_top.sv
// BCP lookup core: propagates queued unit literals through clause nodes held in
// NUM_ENGINE parallel engines, stacks every assignment and flags empty clauses.
module lookup_top #(
    parameter int NUM_ENGINE = 4,
    parameter int LIT_W      = 8,
    parameter int NODE_DEPTH = 16,
    parameter int UQ_DEPTH   = 16,
    parameter int MS_DEPTH   = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    lookup_if.slave bus
);
    localparam int PTR_W = $clog2(NODE_DEPTH) + 1;
    localparam int AW    = PTR_W - 1;
    localparam int ENG_W = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
    localparam int UQ_AW = (UQ_DEPTH > 1) ? $clog2(UQ_DEPTH) : 1;
    localparam int UQ_CW = $clog2(UQ_DEPTH + 1);
    localparam int MS_AW = (MS_DEPTH > 1) ? $clog2(MS_DEPTH) : 1;
    localparam int MS_CW = $clog2(MS_DEPTH + 1);

    typedef logic signed [LIT_W-1:0] lit_t;
    typedef logic [PTR_W-1:0]        ptr_t;
    typedef struct packed {
        lit_t [2:0] lit;
    } node_t;
    typedef enum logic [1:0] {IDLE, FETCH, SCAN, DONE} state_t;

    state_t state, state_next;
    ptr_t   idx, max_end;
    lit_t   cur_lit, neg_lit;
    logic   conflict_q, done_seen;
    logic   scan_go, drain_go, pend_last;

    node_t                 node_mem [NUM_ENGINE][NODE_DEPTH];
    logic [NODE_DEPTH-1:0] alive    [NUM_ENGINE];
    ptr_t                  wr_ptr   [NUM_ENGINE];
    ptr_t                  end_ptr  [NUM_ENGINE];
    logic [ENG_W-1:0]      eng_sel;
    logic [AW-1:0]         idx_a;

    logic [NUM_ENGINE-1:0] pend_valid;
    lit_t                  pend_lit [NUM_ENGINE];
    logic [ENG_W-1:0]      drain_sel;

    node_t                 upd_node [NUM_ENGINE];
    lit_t                  gen_lit  [NUM_ENGINE];
    logic [1:0]            nz_cnt   [NUM_ENGINE];
    logic [NUM_ENGINE-1:0] sat, clr, active, upd_we, kill, gen, confl;

    lit_t             uq_mem [UQ_DEPTH];
    logic [UQ_AW-1:0] uq_rd, uq_wr;
    logic [UQ_CW-1:0] uq_cnt;
    logic             uq_pop, uq_push, uq_push_ok;
    lit_t             uq_push_lit;

    lit_t             ms_mem [MS_DEPTH];
    logic [MS_CW-1:0] ms_cnt;
    logic [MS_AW-1:0] ms_top_a;
    logic             ms_push, ms_pop, ms_full;

    assign idx_a   = idx[AW-1:0];
    assign neg_lit = -cur_lit;

    // Per-engine node evaluation against the current literal at idx.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        scan_go = (state == SCAN) && !bus.halt && (pend_valid == '0);
        for (int e = 0; e < NUM_ENGINE; e++) begin
            upd_node[e] = node_mem[e][idx_a];
            sat[e]      = 1'b0;
            clr[e]      = 1'b0;
            nz_cnt[e]   = '0;
            gen_lit[e]  = '0;
            for (int f = 0; f < 3; f++) begin
                if (node_mem[e][idx_a].lit[f] == cur_lit) sat[e] = 1'b1;
                if (node_mem[e][idx_a].lit[f] == neg_lit) begin
                    upd_node[e].lit[f] = '0;
                    clr[e]             = 1'b1;
                end else if (node_mem[e][idx_a].lit[f] != '0) begin
                    nz_cnt[e]  = nz_cnt[e] + 2'd1;
                    gen_lit[e] = node_mem[e][idx_a].lit[f];
                end
            end
            active[e] = scan_go && (idx < end_ptr[e]) && alive[e][idx_a];
            upd_we[e] = active[e] && !sat[e] && clr[e];
            gen[e]    = upd_we[e] && (nz_cnt[e] == 2'd1);
            confl[e]  = upd_we[e] && (nz_cnt[e] == 2'd0);
            kill[e]   = (active[e] && sat[e]) || gen[e];
        end
    end

    always_comb begin
        max_end   = '0;
        drain_sel = '0;
        for (int e = 0; e < NUM_ENGINE; e++) begin
            if (end_ptr[e] > max_end) max_end = end_ptr[e];
        end
        for (int e = NUM_ENGINE - 1; e >= 0; e--) begin
            if (pend_valid[e]) drain_sel = ENG_W'(e);
        end
        drain_go  = (state == SCAN) && !bus.halt && (pend_valid != '0);
        pend_last = ((pend_valid & (pend_valid - 1'b1)) == '0);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (!bus.halt) state_next = FETCH;
            FETCH: if (!bus.halt) begin
                if (uq_cnt != '0)   state_next = SCAN;
                else if (done_seen) state_next = DONE;
            end
            SCAN:  if (!bus.halt) begin
                if (drain_go) begin
                    if (pend_last && (idx >= max_end)) state_next = FETCH;
                end else if (((idx + 1'b1) >= max_end) && (gen == '0)) begin
                    state_next = FETCH;
                end
            end
            DONE:  state_next = DONE;
        endcase
        if (!bus.halt && (conflict_q || (confl != '0))) state_next = DONE;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cur_lit    <= '0;
            conflict_q <= 1'b0;
            done_seen  <= 1'b0;
            pend_valid <= '0;
            for (int e = 0; e < NUM_ENGINE; e++) pend_lit[e] <= '0;
        end else begin
            // NOTE: registered state uses non-blocking assignments only, so every reader sees pre-edge values.
            state <= state_next;
            if (bus.mem2uca_done) done_seen  <= 1'b1;
            if (confl != '0)      conflict_q <= 1'b1;
            if (uq_pop) begin
                idx     <= '0;
                cur_lit <= uq_mem[uq_rd];
            end else if (scan_go) begin
                idx <= idx + 1'b1;
            end
            for (int e = 0; e < NUM_ENGINE; e++) begin
                if (gen[e]) begin
                    pend_valid[e] <= 1'b1;
                    pend_lit[e]   <= gen_lit[e];
                end else if (drain_go && (drain_sel == ENG_W'(e))) begin
                    pend_valid[e] <= 1'b0;
                end
            end
        end
    end

    // Load path: only while halted. dummy_ptr is applied after the write so it wins.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            eng_sel <= '0;
            for (int e = 0; e < NUM_ENGINE; e++) begin
                wr_ptr[e]  <= '0;
                end_ptr[e] <= '0;
                alive[e]   <= '0;
            end
        end else begin
            for (int e = 0; e < NUM_ENGINE; e++) begin
                if (bus.halt && bus.node_in_valid && (eng_sel == ENG_W'(e)) &&
                    (wr_ptr[e] != ptr_t'(NODE_DEPTH))) begin
                    alive[e][wr_ptr[e][AW-1:0]] <= 1'b1;
                    wr_ptr[e]  <= wr_ptr[e] + 1'b1;
                    end_ptr[e] <= wr_ptr[e] + 1'b1;
                end
                if (bus.halt && bus.dummy_ptr_valid && (eng_sel == ENG_W'(e)))
                    end_ptr[e] <= bus.dummy_ptr;
                if (kill[e]) alive[e][idx_a] <= 1'b0;
            end
            if (bus.halt && bus.change_eng)
                eng_sel <= (eng_sel == ENG_W'(NUM_ENGINE - 1)) ? '0 : eng_sel + 1'b1;
        end
    end

    // NOTE: storage arrays carry no reset; alive bits and counters qualify every read.
    always_ff @(posedge clk) begin
        for (int e = 0; e < NUM_ENGINE; e++) begin
            if (bus.halt && bus.node_in_valid && (eng_sel == ENG_W'(e)) &&
                (wr_ptr[e] != ptr_t'(NODE_DEPTH)))
                node_mem[e][wr_ptr[e][AW-1:0]] <= node_t'(bus.node_in);
            else if (upd_we[e])
                node_mem[e][idx_a] <= upd_node[e];
        end
    end

    // Unit queue: a draining pending unit pre-empts mem2uca in the same cycle.
    assign uq_pop      = (state == FETCH) && !bus.halt && (uq_cnt != '0);
    assign uq_push     = drain_go || bus.mem2uca_valid;
    assign uq_push_lit = drain_go ? pend_lit[drain_sel] : lit_t'(bus.mem2uca);
    assign uq_push_ok  = uq_push && (uq_cnt != UQ_CW'(UQ_DEPTH));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            uq_rd  <= '0;
            uq_wr  <= '0;
            uq_cnt <= '0;
        end else begin
            if (uq_push_ok) uq_wr <= (uq_wr == UQ_AW'(UQ_DEPTH - 1)) ? '0 : uq_wr + 1'b1;
            if (uq_pop)     uq_rd <= (uq_rd == UQ_AW'(UQ_DEPTH - 1)) ? '0 : uq_rd + 1'b1;
            uq_cnt <= uq_cnt + UQ_CW'(uq_push_ok) - UQ_CW'(uq_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (uq_push_ok) uq_mem[uq_wr] <= uq_push_lit;
    end

    // Assignment stack: a same-cycle pop and push replaces the top in place.
    assign ms_push  = uq_pop;
    assign ms_pop   = bus.mstack_pop && (ms_cnt != '0);
    assign ms_full  = (ms_cnt == MS_CW'(MS_DEPTH));
    assign ms_top_a = MS_AW'(ms_cnt - 1'b1);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ms_cnt <= '0;
        end else if (ms_pop && !ms_push) begin
            ms_cnt <= ms_cnt - 1'b1;
        end else if (!ms_pop && ms_push && !ms_full) begin
            ms_cnt <= ms_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ms_pop && ms_push)
            ms_mem[ms_top_a] <= uq_mem[uq_rd];
        else if (ms_push && !ms_full)
            ms_mem[ms_cnt[MS_AW-1:0]] <= uq_mem[uq_rd];
    end

    assign bus.conflict     = conflict_q;
    assign bus.mstack_empty = (ms_cnt == '0);
    assign bus.mstack_lit   = (ms_cnt == '0) ? '0 : ms_mem[ms_top_a];
endmodule

// File: tb/tb_lookup_top.sv
// Scoreboard bench for lookup_top: directed scenarios plus randomized clause sets
// checked against a clause-level propagation model.
module tb_lookup_top;
    localparam int NUM_ENGINE = 4;
    localparam int LIT_W      = 8;
    localparam int NODE_DEPTH = 16;
    localparam int UQ_DEPTH   = 16;
    localparam int MS_DEPTH   = 32;
    localparam int RUN_CYC    = 400;

    logic clk;
    logic rst_n;

    lookup_if #(.LIT_W(LIT_W), .NODE_DEPTH(NODE_DEPTH)) bus ();

    lookup_top #(
        .NUM_ENGINE(NUM_ENGINE), .LIT_W(LIT_W), .NODE_DEPTH(NODE_DEPTH),
        .UQ_DEPTH(UQ_DEPTH), .MS_DEPTH(MS_DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_q[$];
    int mon_lit;

    int m_node [NUM_ENGINE][NODE_DEPTH][3];
    int m_cnt  [NUM_ENGINE];
    int m_end  [NUM_ENGINE];
    int m_units[$];
    int m_eng;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Each stack pop presents the current top; compare it with the next expected entry.
    always @(negedge clk) begin
        if (!rst_n && bus.mstack_pop) begin
            if (exp_q.size() == 0) begin
                check("pop_empty_flag", int'(bus.mstack_empty), 1);
                check("pop_empty_lit", int'($signed(bus.mstack_lit)), 0);
            end else begin
                mon_lit = exp_q.pop_front();
                check("pop_lit", int'($signed(bus.mstack_lit)), mon_lit);
                check("pop_nonempty", int'(bus.mstack_empty), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.halt            = 1'b1;
        bus.node_in         = '0;
        bus.node_in_valid   = 1'b0;
        bus.change_eng      = 1'b0;
        bus.dummy_ptr       = '0;
        bus.dummy_ptr_valid = 1'b0;
        bus.mem2uca         = '0;
        bus.mem2uca_valid   = 1'b0;
        bus.mem2uca_done    = 1'b0;
        bus.mstack_pop      = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        for (int e = 0; e < NUM_ENGINE; e++) begin
            m_cnt[e] = 0;
            m_end[e] = 0;
        end
        m_units.delete();
        exp_q.delete();
        m_eng = 0;
    endtask

    task automatic load_node(input int l2, input int l1, input int l0);
        bus.node_in       = {LIT_W'(l2), LIT_W'(l1), LIT_W'(l0)};
        bus.node_in_valid = 1'b1;
        tick();
        bus.node_in_valid = 1'b0;
        if (m_cnt[m_eng] < NODE_DEPTH) begin
            m_node[m_eng][m_cnt[m_eng]][2] = l2;
            m_node[m_eng][m_cnt[m_eng]][1] = l1;
            m_node[m_eng][m_cnt[m_eng]][0] = l0;
            m_cnt[m_eng]++;
            m_end[m_eng] = m_cnt[m_eng];
        end
    endtask

    task automatic next_eng();
        bus.change_eng = 1'b1;
        tick();
        bus.change_eng = 1'b0;
        m_eng = (m_eng + 1) % NUM_ENGINE;
    endtask

    task automatic set_dummy(input int p);
        bus.dummy_ptr       = (LIT_W)'(p);
        bus.dummy_ptr_valid = 1'b1;
        tick();
        bus.dummy_ptr_valid = 1'b0;
        m_end[m_eng] = p;
    endtask

    task automatic push_unit(input int l);
        bus.mem2uca       = LIT_W'(l);
        bus.mem2uca_valid = 1'b1;
        tick();
        bus.mem2uca_valid = 1'b0;
        m_units.push_back(l);
    endtask

    task automatic run(input int cycles);
        bus.mem2uca_done = 1'b1;
        tick();
        bus.mem2uca_done = 1'b0;
        bus.halt = 1'b0;
        repeat (cycles) tick();
    endtask

    task automatic drain(input int n);
        bus.mstack_pop = 1'b1;
        repeat (n) tick();
        bus.mstack_pop = 1'b0;
    endtask

    // Clause-level propagation: units in FIFO order, nodes by index then engine.
    task automatic model_run(output int m_confl, output int depth);
        int uq[$];
        int stk[$];
        int alv [NUM_ENGINE][NODE_DEPTH];
        int maxe, l, nz, last;
        bit sat_b, clr_b;
        uq      = m_units;
        m_confl = 0;
        maxe    = 0;
        for (int e = 0; e < NUM_ENGINE; e++) begin
            if (m_end[e] > maxe) maxe = m_end[e];
            for (int k = 0; k < NODE_DEPTH; k++) alv[e][k] = (k < m_cnt[e]) ? 1 : 0;
        end
        while (uq.size() > 0 && m_confl == 0) begin
            l = uq.pop_front();
            stk.push_back(l);
            for (int i = 0; i < maxe && m_confl == 0; i++) begin
                for (int e = 0; e < NUM_ENGINE; e++) begin
                    if (i < m_end[e] && alv[e][i] != 0) begin
                        sat_b = 1'b0;
                        for (int f = 0; f < 3; f++) if (m_node[e][i][f] == l) sat_b = 1'b1;
                        if (sat_b) begin
                            alv[e][i] = 0;
                        end else begin
                            clr_b = 1'b0;
                            nz    = 0;
                            last  = 0;
                            for (int f = 0; f < 3; f++) begin
                                if (m_node[e][i][f] == -l) begin
                                    m_node[e][i][f] = 0;
                                    clr_b = 1'b1;
                                end
                            end
                            for (int f = 0; f < 3; f++) begin
                                if (m_node[e][i][f] != 0) begin
                                    nz++;
                                    last = m_node[e][i][f];
                                end
                            end
                            if (clr_b && nz == 1) begin
                                uq.push_back(last);
                                alv[e][i] = 0;
                            end else if (clr_b && nz == 0) begin
                                m_confl = 1;
                            end
                        end
                    end
                end
            end
        end
        depth = stk.size();
        while (stk.size() > 0) exp_q.push_back(stk.pop_back());
    endtask

    function automatic int rand_lit(input bit allow_zero);
        int v;
        if (allow_zero && $urandom_range(0, 3) == 0) return 0;
        v = int'($urandom_range(1, 6));
        return ($urandom_range(0, 1) == 1) ? v : -v;
    endfunction

    int cnt, total, k, depth, mc, nu;

    initial begin
        // Reset values and a pop on an empty stack.
        do_reset();
        check("reset_conflict", int'(bus.conflict), 0);
        check("reset_empty", int'(bus.mstack_empty), 1);
        check("reset_lit", int'($signed(bus.mstack_lit)), 0);
        drain(1);
        check("empty_pop_keeps_empty", int'(bus.mstack_empty), 1);

        // Single engine: +5 clears -5 and leaves 3 as a new unit; DONE ignores later units.
        do_reset();
        load_node(0, 3, -5);
        push_unit(5);
        run(60);
        check("single_conflict", int'(bus.conflict), 0);
        push_unit(7);
        repeat (10) tick();
        exp_q.push_back(3);
        exp_q.push_back(5);
        drain(3);
        check("single_empty_after", int'(bus.mstack_empty), 1);

        // Conflict: clause {0,0,-2} emptied by +2; rises on the edge ending the first SCAN cycle.
        do_reset();
        load_node(0, 0, -2);
        push_unit(2);
        bus.mem2uca_done = 1'b1;
        tick();
        bus.mem2uca_done = 1'b0;
        check("conflict_before_run", int'(bus.conflict), 0);
        bus.halt = 1'b0;
        cnt = 0;
        while (!bus.conflict && cnt < 10) begin
            tick();
            cnt++;
        end
        check("conflict_latency", cnt, 3);
        repeat (20) tick();
        check("conflict_sticky", int'(bus.conflict), 1);
        exp_q.push_back(2);
        drain(2);

        // Two engines each yield a unit at index 0; engine 0 drains first.
        do_reset();
        load_node(-1, 4, 0);
        next_eng();
        load_node(-1, 6, 0);
        push_unit(1);
        run(60);
        check("multi_conflict", int'(bus.conflict), 0);
        exp_q.push_back(6);
        exp_q.push_back(4);
        exp_q.push_back(1);
        drain(4);

        // Satisfied clause stays silent for a later literal.
        do_reset();
        load_node(1, -2, 0);
        push_unit(1);
        push_unit(2);
        run(60);
        check("sat_conflict", int'(bus.conflict), 0);
        exp_q.push_back(2);
        exp_q.push_back(1);
        drain(3);

        // dummy_ptr=1 hides nodes 1 and 2, both of which would conflict.
        do_reset();
        load_node(0, 4, -3);
        load_node(0, 0, -4);
        load_node(0, 0, -3);
        set_dummy(1);
        push_unit(3);
        run(60);
        check("dummy_conflict", int'(bus.conflict), 0);
        exp_q.push_back(4);
        exp_q.push_back(3);
        drain(3);

        // Randomized clause sets against the reference model.
        for (int t = 0; t < 20; t++) begin
            do_reset();
            total = 0;
            for (int e = 0; e < NUM_ENGINE; e++) begin
                k = int'($urandom_range(0, 3));
                if (total + k > 10) k = 10 - total;
                for (int j = 0; j < k; j++) load_node(rand_lit(1), rand_lit(1), rand_lit(1));
                total += k;
                if ($urandom_range(0, 3) == 0) set_dummy(int'($urandom_range(0, k + 2)));
                next_eng();
            end
            nu = int'($urandom_range(1, 4));
            for (int u = 0; u < nu; u++) push_unit(rand_lit(0));
            model_run(mc, depth);
            run(RUN_CYC);
            check("rand_conflict", int'(bus.conflict), mc);
            drain(depth + 1);
            check("rand_empty", int'(bus.mstack_empty), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
